// File: rtl/sound_pkg.sv
// sound_pkg: shared types and the melody table for the sound player.
//   snd_state_e   melody FSM states
//   SEL_LOSE/WIN  melody select codes
//   rom_hp()      half-period (in 50 MHz cycles) of note idx of melody sel
package sound_pkg;

  typedef enum logic [1:0] {
    SND_IDLE,
    SND_NOTE,
    SND_GAP,
    SND_DONE
  } snd_state_e;

  localparam logic SEL_LOSE = 1'b0;
  localparam logic SEL_WIN  = 1'b1;
  localparam int   HP_W     = 17;

  // WIN rises C5-E5-G5-C6, LOSE falls G4-E4-C4-C4.
  function automatic logic [HP_W-1:0] rom_hp(input logic sel, input logic [1:0] idx);
    logic [HP_W-1:0] hp;
    hp = '0;
    if (sel == SEL_WIN) begin
      case (idx)
        2'd0:    hp = 17'd47778;
        2'd1:    hp = 17'd37922;
        2'd2:    hp = 17'd31888;
        default: hp = 17'd23889;
      endcase
    end else begin
      case (idx)
        2'd0:    hp = 17'd63776;
        2'd1:    hp = 17'd75843;
        default: hp = 17'd95557;
      endcase
    end
    return hp;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// tone_divider: square-wave generator with a programmable half period.
//   clk      in  system clock
//   resetN   in  synchronous active-low reset
//   clear    in  hold tone low and preload the counter with hp-1
//   hp       in  half period in clock cycles (>= 1)
//   tone_out out square wave, toggles every hp cycles while clear is low
module tone_divider
  import sound_pkg::*;
(
  input  logic            clk,
  input  logic            resetN,
  input  logic            clear,
  input  logic [HP_W-1:0] hp,
  output logic            tone_out
);

  logic [HP_W-1:0] div_q;
  logic            tone_q;

  always_ff @(posedge clk) begin
    if (!resetN) begin
      div_q  <= '0;
      tone_q <= 1'b0;
    end else if (clear) begin
      div_q  <= hp - 17'd1;
      tone_q <= 1'b0;
    end else if (div_q == '0) begin
      div_q  <= hp - 17'd1;
      tone_q <= ~tone_q;
    end else begin
      div_q  <= div_q - 17'd1;
    end
  end

  assign tone_out = tone_q;

endmodule

// File: rtl/sound_player.sv
// sound_player: plays a 4-note WIN or LOSE melody on a rising edge of
// enable_sound.
//   clk           in  system clock (50 MHz)
//   resetN        in  synchronous active-low reset
//   enable_sound  in  request level; a 0->1 transition in IDLE starts a melody
//   sound_freq_in in  melody select: 0=LOSE, 1=WIN, other values ignored
//   stop          in  synchronous abort
//   tone_out      out square-wave audio
//   playing       out high while notes/gaps are in progress
//   done          out one-cycle pulse after the last note
//   note_idx      out index of the current note
module sound_player
  import sound_pkg::*;
#(
  parameter int NOTE_LEN  = 12_500_000,
  parameter int GAP_LEN   = 2_500_000,
  parameter int DIV_SHIFT = 0,
  parameter int NOTES     = 4
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       enable_sound,
  input  logic [9:0] sound_freq_in,
  input  logic       stop,
  output logic       tone_out,
  output logic       playing,
  output logic       done,
  output logic [1:0] note_idx
);

  localparam int MAX_LEN = (NOTE_LEN > GAP_LEN) ? NOTE_LEN : GAP_LEN;
  localparam int CW      = $clog2(MAX_LEN + 1);
  localparam logic [CW-1:0] NOTE_LOAD = CW'(NOTE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_LEN - 1);
  localparam logic [1:0]    LAST_IDX  = 2'(NOTES - 1);

  snd_state_e      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic            sel_q, sel_d;
  logic            en_q;
  logic            start;
  logic [HP_W-1:0] hp_raw, hp;
  logic            div_clear;

  assign start = enable_sound && !en_q && (sound_freq_in <= 10'd1);

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q <= SND_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sel_q   <= SEL_LOSE;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      en_q    <= enable_sound;  // tracks in every state, so stop also consumes an edge
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    if (stop) begin
      state_d = SND_IDLE;
      cnt_d   = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        SND_IDLE: begin
          if (start) begin
            state_d = SND_NOTE;
            sel_d   = sound_freq_in[0];
            idx_d   = '0;
            cnt_d   = NOTE_LOAD;
          end
        end
        SND_NOTE: begin
          if (cnt_q == '0) begin
            if (idx_q == LAST_IDX) begin
              state_d = SND_DONE;
            end else begin
              state_d = SND_GAP;
              cnt_d   = GAP_LOAD;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        SND_GAP: begin
          if (cnt_q == '0) begin
            state_d = SND_NOTE;
            idx_d   = idx_q + 2'd1;
            cnt_d   = NOTE_LOAD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        SND_DONE: begin
          state_d = SND_IDLE;
          idx_d   = '0;
        end
        default: state_d = SND_IDLE;
      endcase
    end
  end

  // The half period is looked up from the next-state select/index so the
  // divider preloads the right value on the very edge that enters a note.
  assign hp_raw = rom_hp(sel_d, idx_d) >> DIV_SHIFT;
  assign hp     = (hp_raw == '0) ? 17'd1 : hp_raw;

  // Run only while staying inside a note; any entry, exit or non-note
  // cycle holds the tone low with the counter preloaded.
  assign div_clear = !((state_q == SND_NOTE) && (state_d == SND_NOTE));

  tone_divider u_div (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (div_clear),
    .hp       (hp),
    .tone_out (tone_out)
  );

  assign playing  = (state_q == SND_NOTE) || (state_q == SND_GAP);
  assign done     = (state_q == SND_DONE);
  assign note_idx = idx_q;

endmodule

// File: tb/tb_sound_player.sv
// tb_sound_player: directed, table-driven bench for sound_player with
// NOTE_LEN=8, GAP_LEN=4, DIV_SHIFT=14 (WIN hp 2,2,1,1; LOSE hp 3,4,5,5).
module tb_sound_player;

  logic       clk = 1'b0;
  logic       resetN;
  logic       enable_sound;
  logic [9:0] sound_freq_in;
  logic       stop;
  logic       tone_out;
  logic       playing;
  logic       done;
  logic [1:0] note_idx;

  int n_cmp = 0;
  int n_bad = 0;

  sound_player #(
    .NOTE_LEN  (8),
    .GAP_LEN   (4),
    .DIV_SHIFT (14),
    .NOTES     (4)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .enable_sound  (enable_sound),
    .sound_freq_in (sound_freq_in),
    .stop          (stop),
    .tone_out      (tone_out),
    .playing       (playing),
    .done          (done),
    .note_idx      (note_idx)
  );

  always #5 clk = ~clk;

  // Per-note tone pattern: bit j is tone_out j cycles after the note starts.
  typedef struct {
    logic [9:0]      sel;
    logic [9:0]      sel_mid;
    logic            valid;
    logic            hold;
    logic [3:0][7:0] pats;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [9:0] s, input logic [9:0] sm, input logic v,
                              input logic h, input logic [31:0] p);
    vec_t r;
    r.sel = s; r.sel_mid = sm; r.valid = v; r.hold = h; r.pats = p;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_idle(input string name, input int cyc);
    chk({name, ".playing"}, cyc, 32'(playing), 0);
    chk({name, ".tone"}, cyc, 32'(tone_out), 0);
    chk({name, ".idx"}, cyc, 32'(note_idx), 0);
    chk({name, ".done"}, cyc, 32'(done), 0);
  endtask

  initial begin
    int n, off, n_play, n_done, done_cyc;
    logic [7:0] p;
    vec_t v;

    // WIN: CC,CC,AA,AA   LOSE: 38,F0,E0,E0
    vecs[0] = mk(10'd1,    10'd1, 1'b1, 1'b1, {8'hAA, 8'hAA, 8'hCC, 8'hCC});
    vecs[1] = mk(10'd0,    10'd0, 1'b1, 1'b0, {8'hE0, 8'hE0, 8'hF0, 8'h38});
    vecs[2] = mk(10'd1,    10'd0, 1'b1, 1'b0, {8'hAA, 8'hAA, 8'hCC, 8'hCC});
    vecs[3] = mk(10'd2,    10'd2, 1'b0, 1'b0, '0);
    vecs[4] = mk(10'd5,    10'd5, 1'b0, 1'b0, '0);
    vecs[5] = mk(10'd1023, 10'd1, 1'b0, 1'b0, '0);

    resetN = 1'b0; enable_sound = 1'b0; sound_freq_in = '0; stop = 1'b0;
    repeat (3) tick();
    chk_idle("reset", 0);
    resetN = 1'b1;
    tick();

    // Table-driven melodies and invalid selects.
    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      enable_sound = 1'b0; sound_freq_in = v.sel;
      tick();
      enable_sound = 1'b1;
      if (v.valid) begin
        for (int k = 0; k < 44; k++) begin
          tick();
          if (k == 0) sound_freq_in = v.sel_mid;
          n = k / 12; off = k % 12;
          p = v.pats[n];
          chk("mel.playing", k, 32'(playing), 1);
          chk("mel.done", k, 32'(done), 0);
          chk("mel.idx", k, 32'(note_idx), 32'(n));
          chk("mel.tone", k, 32'(tone_out), (off < 8) ? 32'(p[off]) : 0);
        end
        tick();
        chk("end.done", 44, 32'(done), 1);
        chk("end.playing", 44, 32'(playing), 0);
        chk("end.tone", 44, 32'(tone_out), 0);
        tick();
        chk("post.done", 45, 32'(done), 0);
        chk("post.playing", 45, 32'(playing), 0);
        if (v.hold) begin
          for (int k = 0; k < 30; k++) begin
            tick();
            chk("hold.playing", 46 + k, 32'(playing), 0);
            chk("hold.done", 46 + k, 32'(done), 0);
          end
        end
      end else begin
        for (int k = 0; k < 8; k++) begin
          tick();
          chk_idle("invalid", k);
        end
      end
      enable_sound = 1'b0;
      $display("vec %0d sel=%0d valid=%0d checked", i, v.sel, v.valid);
    end

    // Re-pulse and hold enable mid-melody: no restart, one done, no replay.
    enable_sound = 1'b0; sound_freq_in = 10'd1;
    tick();
    enable_sound = 1'b1;
    n_play = 0; n_done = 0; done_cyc = -1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (c == 9) enable_sound = 1'b0;
      if (c == 10) enable_sound = 1'b1;
      if (playing) n_play++;
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
    end
    chk("retrig.play_cycles", 100, 32'(n_play), 44);
    chk("retrig.done_count", 100, 32'(n_done), 1);
    chk("retrig.done_cycle", 100, 32'(done_cyc), 44);
    enable_sound = 1'b0;
    $display("retrigger sequence checked");

    // Stop at cycle 20, then a fresh edge restarts.
    tick();
    enable_sound = 1'b1;
    for (int k = 0; k < 20; k++) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_idle("stop", 20);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk_idle("after_stop", 21 + k);
    end
    enable_sound = 1'b0;
    tick();
    enable_sound = 1'b1;
    tick();
    chk("restart.playing", 0, 32'(playing), 1);
    chk("restart.idx", 0, 32'(note_idx), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    $display("stop sequence checked");

    // Edge coincident with stop is consumed.
    enable_sound = 1'b0;
    tick();
    enable_sound = 1'b1; stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("edge_stop.playing", 0, 32'(playing), 0);
    tick();
    chk("edge_stop.later", 1, 32'(playing), 0);
    $display("edge+stop sequence checked");

    // Reset mid-melody, then enable high at release counts as an edge.
    enable_sound = 1'b0;
    tick();
    enable_sound = 1'b1;
    for (int k = 0; k < 15; k++) tick();
    resetN = 1'b0;
    tick();
    chk_idle("mid_reset", 15);
    resetN = 1'b1;
    tick();
    chk("rst_release.playing", 0, 32'(playing), 1);
    chk("rst_release.idx", 0, 32'(note_idx), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    enable_sound = 1'b0;
    tick();
    $display("reset sequence checked");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
